// File: rtl/vend_dispenser_pkg.sv
// Shared definitions for the vending back end: dispenser state encoding and
// the coin codes exchanged with the coin-accepting FSM.
package vend_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MOTOR    = 3'd1,
        ST_COIN_ON  = 3'd2,
        ST_COIN_GAP = 3'd3,
        ST_FAULT    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_5    = 2'd1,
        COIN_10   = 2'd2,
        COIN_25   = 2'd3
    } coin_e;

    function automatic logic sat_full(input logic [1:0] cnt);
        return cnt == 2'd3;
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// 2-bit saturating up/down counter used as a pending-work queue; ovf_o strobes
// when an increment is dropped because the counter is already full.
module sat_cnt2
    import vend_dispenser_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_o,
    output logic       ovf_o
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        case ({inc_i, dec_i})
            2'b10: begin
                if (sat_full(cnt_q)) ovf_o = 1'b1;
                else                 cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
            end
            default: ;  // idle, or inc and dec cancel out
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= 2'd0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vend_dispenser.sv
// Dispenser back end: queues vend/change pulses, runs the motor handshake and
// the timed change-solenoid pulse, and tracks stock, sold-out and fault status.
module vend_dispenser
    import vend_dispenser_pkg::*;
#(
    parameter int PULSE_W    = 4,
    parameter int MOTOR_TO   = 1000,
    parameter int STOCK_INIT = 15,
    parameter int STOCK_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vend,
    input  logic               chg5,
    input  logic               restock,
    input  logic               motor_done,
    output logic               motor_req,
    output logic               coin_sol,
    output logic               busy,
    output logic               sold_out,
    output logic               missed,
    output logic               overflow,
    output logic               fault,
    output logic [STOCK_W-1:0] stock
);

    localparam int                 TIMER_W      = $clog2(MOTOR_TO + 1);
    localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);
    localparam logic [TIMER_W-1:0] MOTOR_LAST   = TIMER_W'(MOTOR_TO - 1);
    localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(PULSE_W - 1);

    state_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               motor_req_q, coin_sol_q, missed_q, overflow_q, fault_q, sold_out_q;
    logic [1:0]         pv, pc;
    logic               pv_ovf, pc_ovf;
    logic               pv_dec, pc_dec, stock_dec;

    // Dispatch decisions are made from current state so the queues pop on the same edge.
    assign pv_dec    = (state_q == ST_IDLE) && (pv != 2'd0);
    assign pc_dec    = (state_q == ST_IDLE) && (pv == 2'd0) && (pc != 2'd0);
    assign stock_dec = (state_q == ST_MOTOR) && motor_done && (stock_q != '0);

    sat_cnt2 u_pv (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (vend),
        .dec_i   (pv_dec),
        .cnt_o   (pv),
        .ovf_o   (pv_ovf)
    );

    sat_cnt2 u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (vend && chg5),
        .dec_i   (pc_dec),
        .cnt_o   (pc),
        .ovf_o   (pc_ovf)
    );

    always_comb begin
        stock_d = stock_q;
        if (restock)        stock_d = STOCK_RELOAD;
        else if (stock_dec) stock_d = stock_q - STOCK_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            motor_req_q <= 1'b0;
            coin_sol_q  <= 1'b0;
            missed_q    <= 1'b0;
            overflow_q  <= 1'b0;
            fault_q     <= 1'b0;
            stock_q     <= STOCK_RELOAD;
            sold_out_q  <= (STOCK_RELOAD == '0);
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= (stock_d == '0);
            overflow_q <= overflow_q | pv_ovf | pc_ovf;
            missed_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pv != 2'd0 && stock_q != '0) begin
                        state_q     <= ST_MOTOR;
                        timer_q     <= '0;
                        motor_req_q <= 1'b1;
                    end else if (pv != 2'd0) begin
                        missed_q <= 1'b1;  // vend popped with nothing to sell, no refund
                    end else if (pc != 2'd0) begin
                        state_q    <= ST_COIN_ON;
                        timer_q    <= '0;
                        coin_sol_q <= 1'b1;
                    end
                end
                ST_MOTOR: begin
                    if (motor_done) begin
                        state_q     <= ST_IDLE;
                        motor_req_q <= 1'b0;
                    end else if (timer_q == MOTOR_LAST) begin
                        state_q     <= ST_FAULT;
                        motor_req_q <= 1'b0;
                        fault_q     <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_COIN_ON: begin
                    if (timer_q == PULSE_LAST) begin
                        state_q    <= ST_COIN_GAP;
                        timer_q    <= '0;
                        coin_sol_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_COIN_GAP: begin
                    if (timer_q == PULSE_LAST) state_q <= ST_IDLE;
                    else                       timer_q <= timer_q + TIMER_W'(1);
                end
                ST_FAULT: begin
                    motor_req_q <= 1'b0;
                    coin_sol_q  <= 1'b0;
                    fault_q     <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign motor_req = motor_req_q;
    assign coin_sol  = coin_sol_q;
    assign missed    = missed_q;
    assign overflow  = overflow_q;
    assign fault     = fault_q;
    assign stock     = stock_q;
    assign sold_out  = sold_out_q;
    assign busy      = (state_q != ST_IDLE) || (pv != 2'd0) || (pc != 2'd0);

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: a vector table for the basic handshake and
// coin timing, plus hand-written sequences for overflow, sold-out, timeout and reset.
module tb_vend_dispenser;

    logic       clk, reset_n;
    logic       vend, chg5, restock, motor_done;
    logic       motor_req, coin_sol, busy, sold_out, missed, overflow, fault;
    logic [3:0] stock;

    int n_checks = 0;
    int n_errors = 0;

    vend_dispenser dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vend       (vend),
        .chg5       (chg5),
        .restock    (restock),
        .motor_done (motor_done),
        .motor_req  (motor_req),
        .coin_sol   (coin_sol),
        .busy       (busy),
        .sold_out   (sold_out),
        .missed     (missed),
        .overflow   (overflow),
        .fault      (fault),
        .stock      (stock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {motor_req, coin_sol, busy, sold_out, missed, overflow, fault, stock[3:0]}
    typedef struct {
        logic        vend, chg5, restock, done;
        logic [10:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic vd, c, r, d, mr, cs, bz, so, ms, ov, ft,
                                input int st);
        vec_t t;
        t.vend = vd; t.chg5 = c; t.restock = r; t.done = d;
        t.exp  = {mr, cs, bz, so, ms, ov, ft, 4'(st)};
        return t;
    endfunction

    function automatic logic [10:0] outs();
        return {motor_req, coin_sol, busy, sold_out, missed, overflow, fault, stock};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic r, input logic d);
        vend = v; chg5 = c; restock = r; motor_done = d;
        @(posedge clk);
        #1;
        vend = 1'b0; chg5 = 1'b0; restock = 1'b0; motor_done = 1'b0;
    endtask

    task automatic do_reset();
        vend = 1'b0; chg5 = 1'b0; restock = 1'b0; motor_done = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Runs until idle, answering each motor request after 3 cycles; counts events.
    task automatic drain(input int budget, output int n_motor, output int n_coin,
                         output int n_missed, output int bad_width, output bit timed_out);
        logic prev_mr = 1'b0, prev_cs = 1'b0;
        int   mr_len = 0, cs_len = 0;
        n_motor = 0; n_coin = 0; n_missed = 0; bad_width = 0; timed_out = 1'b1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (motor_req && !prev_mr) n_motor++;
            if (coin_sol && !prev_cs)  n_coin++;
            if (!coin_sol && prev_cs && cs_len != 4) bad_width++;
            if (missed) n_missed++;
            mr_len  = motor_req ? mr_len + 1 : 0;
            cs_len  = coin_sol ? cs_len + 1 : 0;
            prev_mr = motor_req;
            prev_cs = coin_sol;
            if (!busy && !coin_sol) begin
                timed_out = 1'b0;
                break;
            end
            step(1'b0, 1'b0, 1'b0, motor_req && (mr_len >= 3));
        end
    endtask

    vec_t vecs[24];

    initial begin
        int nm, nc, nmiss, bw, hi;
        bit to;

        vecs[0]  = mk(1,0,0,0, 0,0,1,0,0,0,0, 15);  // vend queued
        vecs[1]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 15);  // MOTOR entered one edge later
        vecs[2]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 15);
        vecs[3]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 15);
        vecs[4]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 15);
        vecs[5]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 15);
        vecs[6]  = mk(0,0,0,1, 0,0,0,0,0,0,0, 14);  // done: stock-- and idle
        vecs[7]  = mk(0,0,0,0, 0,0,0,0,0,0,0, 14);  // no coin without chg5
        vecs[8]  = mk(1,1,0,0, 0,0,1,0,0,0,0, 14);  // vend+chg5
        vecs[9]  = mk(0,0,0,0, 1,0,1,0,0,0,0, 14);
        vecs[10] = mk(0,0,0,1, 0,0,1,0,0,0,0, 13);  // pc still pending
        vecs[11] = mk(0,0,0,0, 0,1,1,0,0,0,0, 13);  // coin on x4
        vecs[12] = mk(0,0,0,0, 0,1,1,0,0,0,0, 13);
        vecs[13] = mk(0,0,0,0, 0,1,1,0,0,0,0, 13);
        vecs[14] = mk(0,0,0,0, 0,1,1,0,0,0,0, 13);
        vecs[15] = mk(0,0,0,0, 0,0,1,0,0,0,0, 13);  // gap x4
        vecs[16] = mk(0,0,0,0, 0,0,1,0,0,0,0, 13);
        vecs[17] = mk(0,0,0,0, 0,0,1,0,0,0,0, 13);
        vecs[18] = mk(0,0,0,0, 0,0,1,0,0,0,0, 13);
        vecs[19] = mk(0,0,0,0, 0,0,0,0,0,0,0, 13);  // idle again
        vecs[20] = mk(0,0,0,1, 0,0,0,0,0,0,0, 13);  // motor_done ignored in IDLE
        vecs[21] = mk(0,0,1,0, 0,0,0,0,0,0,0, 15);  // restock
        vecs[22] = mk(0,1,0,0, 0,0,0,0,0,0,0, 15);  // chg5 alone ignored
        vecs[23] = mk(0,0,0,0, 0,0,0,0,0,0,0, 15);

        do_reset();
        check("reset_state", 32'(outs()), 32'({7'b0, 4'd15}));

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].vend, vecs[i].chg5, vecs[i].restock, vecs[i].done);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Back-to-back: four vend+chg5 pulses while the first product is in MOTOR.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_in_motor", 32'(motor_req), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_no_ovf_at_3", 32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_ovf_at_4", 32'(overflow), 32'd1);
        drain(400, nm, nc, nmiss, bw, to);
        check("b2b_drain_to", 32'(to), 32'd0);
        check("b2b_motor_cnt", 32'(nm), 32'd4);
        check("b2b_coin_cnt", 32'(nc), 32'd3);
        check("b2b_coin_width", 32'(bw), 32'd0);
        check("b2b_stock", 32'(stock), 32'd11);
        check("b2b_ovf_sticky", 32'(overflow), 32'd1);

        // Sold out: bring stock to 1, then two vends -> one sale and one miss.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            drain(100, nm, nc, nmiss, bw, to);
        end
        check("so_stock_1", 32'(stock), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        drain(100, nm, nc, nmiss, bw, to);
        check("so_drain_to", 32'(to), 32'd0);
        check("so_motor_cnt", 32'(nm), 32'd1);
        check("so_missed_cnt", 32'(nmiss), 32'd1);
        check("so_stock_0", 32'(stock), 32'd0);
        check("so_flag", 32'(sold_out), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("so_restock_stock", 32'(stock), 32'd15);
        check("so_restock_flag", 32'(sold_out), 32'd0);

        // Motor timeout: motor_req high for exactly 1000 cycles, then FAULT.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        hi = motor_req ? 1 : 0;
        while (motor_req && hi < 1100) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (motor_req) hi++;
        end
        check("to_cycles", 32'(hi), 32'd1000);
        check("to_fault", 32'(fault), 32'd1);
        check("to_motor_off", 32'(motor_req), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (motor_req) hi++;
        end
        check("to_no_dispatch", 32'(hi), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("to_restock_keeps_fault", 32'({fault, stock}), 32'({1'b1, 4'd15}));

        // Reset asserted during COIN_ON drops the solenoid without a clock edge.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_coin_on", 32'({coin_sol, stock}), 32'({1'b1, 4'd14}));
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_coin", 32'({motor_req, coin_sol}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_after_release", 32'(outs()), 32'({7'b0, 4'd15}));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Back end of the vending controller. Consumes the one-cycle `vend` and `chg5` pulses produced by the coin-accepting FSM.
- Drives the product motor through a request/done handshake and the 5-unit change solenoid with a timed pulse.
- Queues pulses that arrive while a dispense is in progress, tracks product stock, and reports sold-out and fault conditions.

Parameters:
- PULSE_W, 4: cycles the coin solenoid is held high per coin; also the length of the mandatory low gap after each coin.
- MOTOR_TO, 1000: maximum number of cycles `motor_req` may stay high without `motor_done` before a fault is raised.
- STOCK_INIT, 15: stock value loaded at reset and on `restock`.
- STOCK_W, 4: width of the stock counter. STOCK_INIT must fit in it.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vend  in  1  one-cycle pulse: dispense one product.
- chg5  in  1  one-cycle pulse, meaningful only together with `vend`: return one 5-unit coin.
- restock  in  1  one-cycle pulse: reload stock to STOCK_INIT.
- motor_done  in  1  level or pulse from the motor driver: product has dropped.
- motor_req  out  1  product motor request, held high until `motor_done`.
- coin_sol  out  1  change solenoid drive.
- busy  out  1  high while any work is pending or in progress.
- sold_out  out  1  high when stock == 0.
- missed  out  1  one-cycle pulse: a queued vend was discarded because stock was 0.
- overflow  out  1  sticky: a pulse was lost because its queue was saturated.
- fault  out  1  sticky: motor timeout.
- stock  out  STOCK_W  current stock count.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - State goes to IDLE; both queues clear; timers clear.
  - motor_req, coin_sol, missed, overflow and fault all go to 0.
  - stock = STOCK_INIT.
- Queues:
  - Two 2-bit saturating counters: pv (pending vends) and pc (pending change), each 0..3.
  - `vend` increments pv. `vend && chg5` also increments pc.
  - `chg5` without `vend` is ignored.
  - An increment on a saturated counter (value 3) is dropped and sets `overflow`.
  - An increment and a dispatch decrement in the same cycle leave the counter unchanged and do not set `overflow`.
- FSM states: IDLE, MOTOR, COIN_ON, COIN_GAP, FAULT. All outputs are registered.
- IDLE, evaluated in priority order:
  1. pv > 0 and stock > 0: pv--, go to MOTOR, clear the timer.
  2. pv > 0 and stock == 0: pv--, pulse `missed` for one cycle, stay in IDLE. No refund is issued.
  3. pc > 0: pc--, go to COIN_ON, clear the timer.
  4. Otherwise stay in IDLE.
- MOTOR:
  - motor_req = 1; the timer increments every cycle.
  - On `motor_done`: stock--, go to IDLE. motor_req falls on that transition.
  - If the timer reaches MOTOR_TO before `motor_done`: go to FAULT.
- COIN_ON: coin_sol = 1 for exactly PULSE_W cycles, then go to COIN_GAP.
- COIN_GAP: coin_sol = 0 for exactly PULSE_W cycles, then go to IDLE.
- FAULT:
  - fault = 1, motor_req = 0, coin_sol = 0.
  - Terminal until reset. Queues keep counting but are not dispatched.
- Latency: a `vend` sampled at edge E0 gives pv = 1 after E0, the FSM enters MOTOR at E1, and motor_req is high after E1. A change coin follows the product with no extra idle cycle.
- Ordering for one vend+chg5 pair: motor handshake, then one coin pulse.
- `motor_done` is ignored outside MOTOR.
- Stock:
  - Never decrements below 0.
  - `restock` takes priority over a simultaneous decrement.
  - `restock` is accepted in every state, including FAULT, but does not clear `fault`.
- Status outputs:
  - sold_out = (stock == 0), registered, so it follows stock with no lag.
  - busy = (state != IDLE) or (pv != 0) or (pc != 0).
- Reset asserted mid-MOTOR or mid-COIN_ON drops motor_req and coin_sol asynchronously; all queued work is lost.

Decomposition:
- Shared package: state encoding constants (IDLE, MOTOR, COIN_ON, COIN_GAP, FAULT) and the coin code constants shared with the vending FSM.
- One sub-module is natural: `sat_cnt2`, a 2-bit saturating up/down counter with an overflow strobe, instantiated once for pv and once for pc.

Test Plan:
- Single vend, no change: vend at E0 → motor_req high after E1. Assert motor_done 5 cycles later → motor_req low, stock 15→14, coin_sol never rises, busy falls.
- vend+chg5: after motor_done, coin_sol is high for exactly 4 cycles, then low for 4; busy falls after the gap; pc returns to 0.
- Back-to-back: 4 vend pulses (with chg5) sent on consecutive cycles while the first is in MOTOR → overflow set on the 4th. Exactly 3 motor handshakes and 3 coin pulses follow.
- Sold out: start with stock at 1 and issue 2 vends → one motor handshake, stock reaches 0, sold_out = 1, one `missed` pulse. Then `restock` → stock = 15, sold_out = 0.
- Timeout: vend with motor_done held low → after 1000 cycles of motor_req, fault = 1 and motor_req = 0. Further vends raise pv but produce no motor_req.
- Reset mid-coin: reset_n driven low during COIN_ON → coin_sol falls immediately. After release: stock = 15, all flags 0, busy = 0.
